vrf_op_requester: RTL
=====================

Name: vrf_op_requester

Overview:
- Sits directly downstream of the vector instruction launcher's operand-request port.
- Accepts one operand request at a time: source registers vs1/vs2, per-queue enable mask, byte length vlB.
- Issues word-sized VRF read requests per operand queue and collects the 1-cycle-latency read data into per-queue FIFOs.
- The VFUs drain operands from those FIFOs through valid/ready.

Parameters:
- VLENB, 64, vector register length in bytes
- DataBytes, 8, bytes per VRF read word (power of 2)
- NrOpQueue, 2, number of operand queues; queue 0 reads vs1, queue 1 reads vs2
- QueueDepth, 4, entries per operand FIFO

Derived values:
- WordsPerReg = VLENB/DataBytes
- AddrW = 5+$clog2(WordsPerReg)
- VlBW = $clog2(8*VLENB)+1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- op_req_valid_i  in  1  operand request valid
- op_req_ready_o  out  1  requester idle, can accept a request
- op_req_vs1_i  in  5  source register for queue 0
- op_req_vs2_i  in  5  source register for queue 1
- op_req_queue_i  in  NrOpQueue  per-queue enable mask
- op_req_vlB_i  in  VlBW  operand length in bytes
- vrf_rd_valid_o  in/out: out  NrOpQueue  read request per queue
- vrf_rd_addr_o  out  NrOpQueue*AddrW  word address per queue
- vrf_rd_gnt_i  in  NrOpQueue  read granted this cycle
- vrf_rd_data_i  in  NrOpQueue*8*DataBytes  read data, valid exactly 1 cycle after grant
- opq_valid_o  out  NrOpQueue  FIFO head valid
- opq_data_o  out  NrOpQueue*8*DataBytes  FIFO head data
- opq_ready_i  in  NrOpQueue  consumer pops head

Behaviour:
- Reset (rst_ni low at clk_i edge):
  - state=IDLE; all counters, FIFOs and in-flight flags cleared.
  - While rst_ni is low: op_req_ready_o=0, vrf_rd_valid_o=0, opq_valid_o=0.
  - Reset mid-operation aborts the request; data returning the cycle after reset is dropped.
- FSM IDLE/BUSY:
  - op_req_ready_o = (state==IDLE) && rst_ni.
  - Handshake in IDLE latches: base address per queue = vsX*WordsPerReg; per-queue remaining count = enable ? ceil(vlB/DataBytes) : 0; word index = 0.
  - Any nonzero count -> BUSY; otherwise stay IDLE (vlB=0 or mask=0 completes in the same cycle, no reads).
  - BUSY -> IDLE on the edge where the last remaining grant occurs.
  - A new request can be accepted the cycle after that edge; in-flight data and FIFO contents are unaffected by the new request.
- Word count: words = (vlB + DataBytes-1) >> log2(DataBytes).
- Address:
  - vrf_rd_addr_o[q] = (base + idx) mod 2^AddrW.
  - Wraps past v31 to v0; no error.
  - idx increments on each grant.
- Read issue:
  - vrf_rd_valid_o[q] = BUSY && remaining[q]!=0 && credit[q]<QueueDepth.
  - credit[q] = FIFO occupancy + in-flight(0/1).
  - Address and valid are stable until granted.
  - A grant while valid is low is ignored.
- Return path:
  - grant at cycle t sets in-flight[q]; data is written into FIFO q at edge t+1.
  - The word is visible on opq_valid_o at t+2.
  - No bypass.
- FIFO:
  - pop when opq_valid_o && opq_ready_i; order preserved.
  - Simultaneous push and pop on a full FIFO is legal, since credits guarantee no overflow.
  - opq_data_o is don't-care when opq_valid_o=0.
- Queues are fully independent: a stall (no grant or no credit) on one queue never blocks the other.
- Throughput: with continuous grants and pops, a queue sustains one word per cycle.

Test Plan:
1. VLENB=64, vs1=3, mask=01, vlB=32, grant always, ready always -> addrs 24,25,26,27 on consecutive cycles; queue0 outputs 4 words in order, the first 2 cycles after the first grant; op_req_ready_o high again the cycle after grant 4; queue 1 never valid.
2. vlB=13, mask=11, vs1=0, vs2=1 -> 2 reads per queue (addrs 0,1 and 8,9); vlB=0 -> no vrf_rd_valid_o, op_req_ready_o stays 1.
3. opq_ready_i[0]=0, vlB=64 -> exactly 4 grants, then vrf_rd_valid_o[0] low with addr held at base+4; raise ready -> remaining 4 words delivered, total 8 in order.
4. mask=11, vrf_rd_gnt_i[1] held 0 for 10 cycles -> queue 0 completes all words unaffected; FSM stays BUSY until queue 1 finishes.
5. vs2=31, mask=10, vlB=128 -> addrs 248..255 then 0..7 (wrap).
6. Assert rst_ni low for 1 cycle after 2 grants of an 8-word request -> all valids 0 during reset; after reset FIFOs empty, op_req_ready_o=1; the data word from the in-flight grant never appears.

Source files
------------

// File: rtl/vrf_op_requester.sv
// -----------------------------------------------------------------------------
// vrf_op_requester
//
// Purpose:
//   Accepts one operand request at a time from the vector instruction
//   launcher and turns it into word-sized VRF reads, one stream per operand
//   queue. Queue 0 reads register vs1 and queue 1 reads register vs2. Read
//   data returns one cycle after the grant and lands in a small per-queue
//   FIFO, which the VFUs drain through valid/ready.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   op_req_valid_i/ready_o request handshake (ready only while idle)
//   op_req_vs1_i/vs2_i     source registers for queue 0 / queue 1
//   op_req_queue_i         per-queue enable mask
//   op_req_vlB_i           operand length in bytes
//   vrf_rd_valid_o/addr_o  per-queue read request and word address
//   vrf_rd_gnt_i           per-queue grant (ignored while valid is low)
//   vrf_rd_data_i          per-queue read data, one cycle after the grant
//   opq_valid_o/data_o     per-queue FIFO head
//   opq_ready_i            per-queue pop
// -----------------------------------------------------------------------------
module vrf_op_requester #(
  parameter int VLENB      = 64,
  parameter int DataBytes  = 8,
  parameter int NrOpQueue  = 2,
  parameter int QueueDepth = 4,
  localparam int WordsPerReg = VLENB / DataBytes,
  localparam int AddrW       = 5 + $clog2(WordsPerReg),
  localparam int VlBW        = $clog2(8 * VLENB) + 1,
  localparam int DataW       = 8 * DataBytes
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       op_req_valid_i,
  output logic                       op_req_ready_o,
  input  logic [4:0]                 op_req_vs1_i,
  input  logic [4:0]                 op_req_vs2_i,
  input  logic [NrOpQueue-1:0]       op_req_queue_i,
  input  logic [VlBW-1:0]            op_req_vlB_i,
  output logic [NrOpQueue-1:0]       vrf_rd_valid_o,
  output logic [NrOpQueue*AddrW-1:0] vrf_rd_addr_o,
  input  logic [NrOpQueue-1:0]       vrf_rd_gnt_i,
  input  logic [NrOpQueue*DataW-1:0] vrf_rd_data_i,
  output logic [NrOpQueue-1:0]       opq_valid_o,
  output logic [NrOpQueue*DataW-1:0] opq_data_o,
  input  logic [NrOpQueue-1:0]       opq_ready_i
);

  localparam int PtrW     = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int CntW     = $clog2(QueueDepth + 1);
  localparam int RegShift = $clog2(WordsPerReg);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [AddrW-1:0]     base_q     [NrOpQueue];
  logic [AddrW-1:0]     base_d     [NrOpQueue];
  logic [AddrW-1:0]     idx_q      [NrOpQueue];
  logic [AddrW-1:0]     idx_d      [NrOpQueue];
  logic [VlBW-1:0]      rem_q      [NrOpQueue];
  logic [VlBW-1:0]      rem_d      [NrOpQueue];
  logic [NrOpQueue-1:0] inflight_q, inflight_d;
  logic [PtrW-1:0]      wr_ptr_q   [NrOpQueue];
  logic [PtrW-1:0]      wr_ptr_d   [NrOpQueue];
  logic [PtrW-1:0]      rd_ptr_q   [NrOpQueue];
  logic [PtrW-1:0]      rd_ptr_d   [NrOpQueue];
  logic [CntW-1:0]      cnt_q      [NrOpQueue];
  logic [CntW-1:0]      cnt_d      [NrOpQueue];
  logic [DataW-1:0]     mem_q      [NrOpQueue][QueueDepth];
  logic [DataW-1:0]     mem_d      [NrOpQueue][QueueDepth];

  logic                 req_fire;
  logic                 any_rem;
  logic [VlBW-1:0]      words;
  logic [NrOpQueue-1:0] gnt_eff;
  logic [NrOpQueue-1:0] push;
  logic [NrOpQueue-1:0] pop;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(QueueDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reset gates every handshake output so nothing moves while rst_ni is low,
  // even before the first reset edge has cleared the state.
  assign op_req_ready_o = (state_q == IDLE) && rst_ni;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a bit unassigned, which would infer a latch.
    vrf_rd_valid_o = '0;
    vrf_rd_addr_o  = '0;
    opq_valid_o    = '0;
    opq_data_o     = '0;
    for (int q = 0; q < NrOpQueue; q++) begin
      // A read may only issue when the FIFO is guaranteed a free slot for
      // its return data, counting the word already in flight.
      vrf_rd_valid_o[q] = rst_ni && (state_q == BUSY) && (rem_q[q] != '0) &&
                          (((CntW+1)'(cnt_q[q]) + (CntW+1)'(inflight_q[q])) <
                           (CntW+1)'(QueueDepth));
      vrf_rd_addr_o[q*AddrW +: AddrW] = base_q[q] + idx_q[q];
      opq_valid_o[q] = rst_ni && (cnt_q[q] != '0);
      opq_data_o[q*DataW +: DataW]    = mem_q[q][rd_ptr_q[q]];
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    gnt_eff    = '0;
    push       = '0;
    pop        = '0;
    any_rem    = 1'b0;

    req_fire = op_req_valid_i && op_req_ready_o;
    // Round the byte length up to whole words; one spare bit absorbs the carry.
    words = VlBW'(({1'b0, op_req_vlB_i} + (VlBW+1)'(DataBytes - 1)) >> $clog2(DataBytes));

    for (int q = 0; q < NrOpQueue; q++) begin
      gnt_eff[q]    = vrf_rd_gnt_i[q] && vrf_rd_valid_o[q];
      push[q]       = inflight_q[q];
      pop[q]        = opq_valid_o[q] && opq_ready_i[q];
      inflight_d[q] = gnt_eff[q];

      if (push[q]) begin
        mem_d[q][wr_ptr_q[q]] = vrf_rd_data_i[q*DataW +: DataW];
        wr_ptr_d[q]           = inc_ptr(wr_ptr_q[q]);
      end
      if (pop[q]) rd_ptr_d[q] = inc_ptr(rd_ptr_q[q]);

      unique case ({push[q], pop[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + 1'b1;
        2'b01:   cnt_d[q] = cnt_q[q] - 1'b1;
        default: cnt_d[q] = cnt_q[q];
      endcase

      // Requests are only accepted while idle, when no grant can be pending.
      if (req_fire) begin
        base_d[q] = AddrW'((q == 0) ? op_req_vs1_i : op_req_vs2_i) << RegShift;
        idx_d[q]  = '0;
        rem_d[q]  = op_req_queue_i[q] ? words : '0;
      end else if (gnt_eff[q]) begin
        idx_d[q]  = idx_q[q] + 1'b1;
        rem_d[q]  = rem_q[q] - 1'b1;
      end

      if (rem_d[q] != '0) any_rem = 1'b1;
    end

    unique case (state_q)
      IDLE:    if (req_fire && any_rem) state_d = BUSY;
      BUSY:    if (!any_rem)            state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q     <= '{default: '0};
      idx_q      <= '{default: '0};
      rem_q      <= '{default: '0};
      inflight_q <= '0;
      wr_ptr_q   <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      cnt_q      <= '{default: '0};
    end else begin
      base_q     <= base_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; an entry is only read after it has been
  // written, because the occupancy counters are reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
